// File: rtl/fp_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_operand_sequencer_if
// Brief    : Command, FP-unit operand/result and response bundle for the
//            operand sequencer. rsp_nan exists only with FP_SEQ_NAN_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_operand_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [31:0] cmd_c;

    logic        io_a_valid;
    logic        io_b_valid;
    logic        io_c_valid;
    logic [31:0] io_a_bits;
    logic [31:0] io_b_bits;
    logic [31:0] io_c_bits;

    logic        io_result_valid;
    logic [31:0] io_result_bits;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_bits;
    logic        rsp_timeout;
`ifdef FP_SEQ_NAN_FLAG_EN
    logic        rsp_nan;
`endif

    // Environment side: command producer, FP unit and response consumer.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_c,
        output io_result_valid, io_result_bits,
        output rsp_ready,
        input  cmd_ready,
        input  io_a_valid, io_b_valid, io_c_valid,
        input  io_a_bits, io_b_bits, io_c_bits,
        input  rsp_valid, rsp_bits, rsp_timeout
`ifdef FP_SEQ_NAN_FLAG_EN
        , input rsp_nan
`endif
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_c,
        input  io_result_valid, io_result_bits,
        input  rsp_ready,
        output cmd_ready,
        output io_a_valid, io_b_valid, io_c_valid,
        output io_a_bits, io_b_bits, io_c_bits,
        output rsp_valid, rsp_bits, rsp_timeout
`ifdef FP_SEQ_NAN_FLAG_EN
        , output rsp_nan
`endif
    );
endinterface
`default_nettype wire

// File: rtl/fp_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp_operand_sequencer
// Brief    : Issues a latched operand triple to an FP unit one operand per
//            cycle, waits for the result with a timeout, and holds the
//            response until taken. Optional macro: FP_SEQ_NAN_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fp_operand_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  wire logic            clock,
    input  wire logic            reset,
    fp_operand_sequencer_if.slave bus
);

    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;
    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_A = 3'd1,
        S_ISSUE_B = 3'd2,
        S_ISSUE_C = 3'd3,
        S_WAIT    = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_c;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_rsp_bits;
    logic        r_rsp_timeout;
    logic        r_rst_done;

    logic        w_accept;
    logic        w_take_result;
    logic        w_take_timeout;

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_take_result  = 1'b0;
        w_take_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && r_rst_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE_A;
                end
            end
            S_ISSUE_A: w_state_nxt = S_ISSUE_B;
            S_ISSUE_B: w_state_nxt = S_ISSUE_C;
            S_ISSUE_C: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A result arriving on the final WAIT cycle still wins.
                if (bus.io_result_valid) begin
                    w_take_result = 1'b1;
                    w_state_nxt   = S_RESP;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_take_timeout = 1'b1;
                    w_state_nxt    = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holds cmd_ready low until the first clock edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a <= 32'h0;
            r_b <= 32'h0;
            r_c <= 32'h0;
        end else if (w_accept) begin
            r_a <= bus.cmd_a;
            r_b <= bus.cmd_b;
            r_c <= bus.cmd_c;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 16'h0;
        end else if (r_state == S_ISSUE_C) begin
            r_wait_cnt <= 16'h0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 16'h1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rsp_bits    <= 32'h0;
            r_rsp_timeout <= 1'b0;
        end else if (w_take_result) begin
            r_rsp_bits    <= bus.io_result_bits;
            r_rsp_timeout <= 1'b0;
        end else if (w_take_timeout) begin
            r_rsp_bits    <= c_QNAN;
            r_rsp_timeout <= 1'b1;
        end
    end

    assign bus.cmd_ready   = (r_state == S_IDLE) && r_rst_done;
    assign bus.io_a_valid  = (r_state == S_ISSUE_A);
    assign bus.io_b_valid  = (r_state == S_ISSUE_B);
    assign bus.io_c_valid  = (r_state == S_ISSUE_C);
    assign bus.io_a_bits   = r_a;
    assign bus.io_b_bits   = r_b;
    assign bus.io_c_bits   = r_c;
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_bits    = r_rsp_bits;
    assign bus.rsp_timeout = r_rsp_timeout;

`ifdef FP_SEQ_NAN_FLAG_EN
    assign bus.rsp_nan = (r_state == S_RESP) && (&r_rsp_bits[30:23]) && (|r_rsp_bits[22:0]);
`endif

endmodule
`default_nettype wire

// File: doc/fp_operand_sequencer.md
FP_OPERAND_SEQUENCER -- requirements
Module: fp_operand_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of WAIT cycles before a response is forced (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1, an operand triple is offered.
REQ-005 SHALL have port cmd_ready, output, 1, the sequencer accepts a triple this cycle.
REQ-006 SHALL have ports cmd_a, cmd_b, cmd_c, input, 32 each, IEEE-754 single operands.
REQ-007 SHALL have ports io_a_valid, io_b_valid, io_c_valid, output, 1 each, one-cycle operand strobes to the FP unit.
REQ-008 SHALL have ports io_a_bits, io_b_bits, io_c_bits, output, 32 each, operand values to the FP unit.
REQ-009 SHALL have port io_result_valid, input, 1, the FP unit result strobe.
REQ-010 SHALL have port io_result_bits, input, 32, the FP unit result value.
REQ-011 SHALL have port rsp_valid, output, 1, a response is held for the consumer.
REQ-012 SHALL have port rsp_ready, input, 1, the consumer takes the response.
REQ-013 SHALL have port rsp_bits, output, 32, the captured result.
REQ-014 SHALL have port rsp_timeout, output, 1, the response was forced by timeout.

Function
REQ-015 SHALL implement states IDLE, ISSUE_A, ISSUE_B, ISSUE_C, WAIT and RESP.
REQ-016 SHALL drive cmd_ready high only in IDLE; when cmd_valid and cmd_ready are both high in cycle N, cmd_a/b/c SHALL be latched and the state SHALL move to ISSUE_A.
REQ-017 SHALL assert io_a_valid in cycle N+1 (ISSUE_A), io_b_valid in N+2 (ISSUE_B) and io_c_valid in N+3 (ISSUE_C), each for exactly one cycle, then enter WAIT in N+4.
REQ-018 SHALL drive io_*_bits continuously from the latched operand registers, with the values holding until the next accepted command.
REQ-019 SHALL ignore io_result_valid in any state other than WAIT.
REQ-020 SHALL, on io_result_valid in WAIT in cycle M, capture io_result_bits, clear rsp_timeout and assert rsp_valid in M+1 (RESP).
REQ-021 SHALL clear a wait counter on WAIT entry and increment it each WAIT cycle; when the counter equals TIMEOUT_CYCLES-1 with no io_result_valid, it SHALL go to RESP with rsp_bits=32'h7FC00000 and rsp_timeout=1.
REQ-022 SHALL give io_result_valid priority over timeout when both occur in the same cycle.
REQ-023 SHALL hold rsp_valid, rsp_bits and rsp_timeout stable in RESP until rsp_ready is high, then return to IDLE the next cycle; rsp_ready SHALL have no effect outside RESP.
REQ-024 SHALL hold at most one command in flight; a new command is accepted only in IDLE, so the minimum accept-to-accept spacing is 6 cycles.

Reset
REQ-025 SHALL, while reset is low, force state IDLE and clear all operand registers, the counter, rsp_bits and rsp_timeout, independent of clock.
REQ-026 SHALL, while reset is low, drive cmd_ready=0, io_*_valid=0, io_*_bits=0 and rsp_valid=0; cmd_ready SHALL rise in the first cycle after release.
REQ-027 SHALL, on reset asserted mid-sequence, abandon the sequence; any result arriving after release SHALL be ignored, per REQ-019.

Configuration
REQ-028 SHALL, when macro FP_SEQ_NAN_FLAG_EN is defined, add output rsp_nan (1 bit), high in RESP when rsp_bits has exponent 8'hFF and a nonzero mantissa (including the timeout value), and reset to 0.
REQ-029 SHALL, when FP_SEQ_NAN_FLAG_EN is undefined, have no rsp_nan port and no NaN-detect logic; all other behaviour is identical.

Verification
REQ-030 Bench SHALL cover the basic sequence: cmd a=3F800000, b=3F800000, c=00000000 accepted at cycle N -> a/b/c strobes at N+1/N+2/N+3; result 3F800000 at M -> rsp_valid at M+1, rsp_bits=3F800000, rsp_timeout=0.
REQ-031 Bench SHALL cover timeout: TIMEOUT_CYCLES=8 and no result -> rsp_valid after 8 WAIT cycles, rsp_bits=7FC00000, rsp_timeout=1, plus rsp_nan=1 when the macro is defined.
REQ-032 Bench SHALL cover priority: result 40000000 in the same cycle as timeout expiry -> rsp_bits=40000000, rsp_timeout=0.
REQ-033 Bench SHALL cover backpressure and stray results: rsp_ready low for 5 cycles -> rsp fields stable, cmd_ready=0; a stray io_result_valid during ISSUE_B -> no response change.
REQ-034 Bench SHALL cover reset mid-operation: reset low during WAIT -> all outputs 0 immediately; after release, a result pulse -> no rsp_valid and cmd_ready=1.
